// File: rtl/pipelined_mac_if.sv
// Operand-side and result-side valid/ready streams of the pipelined MAC.
interface pipelined_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              acc_en;
  logic              acc_clr;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  modport master (
    output in_valid, a, b, acc_en, acc_clr, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, a, b, acc_en, acc_clr, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/pipelined_mac.sv
// Pipelined multiply-accumulate: product register, optional delay stages, then
// an output/accumulate register; the whole pipe stalls on result backpressure.
module pipelined_mac #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int PIPE_STAGES = 2,
  parameter bit SIGNED      = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  pipelined_mac_if.slave mac
);
  localparam int PW = 2 * DATA_W;
  localparam int P  = PIPE_STAGES - 1;  // stages carrying a product

  typedef struct packed {
    logic          acc_en;
    logic          acc_clr;
    logic          last;
    logic [PW-1:0] prod;
  } beat_t;

  logic             adv;
  logic [P:1]       vld_pipe;
  beat_t [P:1]      beat_pipe;
  beat_t            beat_in;
  logic [PW-1:0]    a_ext, b_ext;
  logic [ACC_W-1:0] acc, prod_ext, acc_nxt;
  logic [ACC_W:0]   sum;
  logic             ovf_sticky, add_ovf, ovf_nxt;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf, out_valid;

  assign adv           = !out_valid || mac.out_ready;
  assign mac.in_ready  = adv && !reset;
  assign mac.out_valid = out_valid;
  assign mac.out_data  = out_data;
  assign mac.out_ovf   = out_ovf;

  // Extending to 2*DATA_W first makes the low half of one multiplier correct
  // for both signed and unsigned operands.
  assign a_ext = {{DATA_W{SIGNED & mac.a[DATA_W-1]}}, mac.a};
  assign b_ext = {{DATA_W{SIGNED & mac.b[DATA_W-1]}}, mac.b};

  always_comb begin
    beat_in         = '0;
    beat_in.acc_en  = mac.acc_en;
    beat_in.acc_clr = mac.acc_clr;
    beat_in.last    = mac.in_last;
    beat_in.prod    = a_ext * b_ext;
  end

  assign prod_ext = SIGNED ? ACC_W'($signed(beat_pipe[P].prod))
                           : ACC_W'(beat_pipe[P].prod);
  assign sum      = {1'b0, acc} + {1'b0, prod_ext};
  assign add_ovf  = SIGNED ? ((acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                              (sum[ACC_W-1] != acc[ACC_W-1]))
                           : sum[ACC_W];
  assign acc_nxt  = beat_pipe[P].acc_clr ? prod_ext : sum[ACC_W-1:0];
  assign ovf_nxt  = !beat_pipe[P].acc_clr && (ovf_sticky || add_ovf);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      beat_pipe  <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (adv) begin
      vld_pipe[1]  <= mac.in_valid;
      beat_pipe[1] <= beat_in;
      for (int s = 2; s <= P; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        beat_pipe[s] <= beat_pipe[s-1];
      end
      out_valid <= 1'b0;
      if (vld_pipe[P]) begin
        if (!beat_pipe[P].acc_en) begin
          out_data  <= prod_ext;
          out_ovf   <= 1'b0;
          out_valid <= 1'b1;
        end else begin
          acc        <= acc_nxt;
          ovf_sticky <= ovf_nxt;
          if (beat_pipe[P].last) begin
            out_data  <= acc_nxt;
            out_ovf   <= ovf_nxt;
            out_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule
